// File: rtl/router_4lane_pkg.sv
// rtl/router_4lane_pkg.sv - shared constants and types for the router_4lane request path
package router_4lane_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int XFER_BITS  = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_COMPLETE
  } disp_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src;
    logic [DEF_ADDR_W-1:0] dst;
  } router_req_t;

endpackage

// File: rtl/router_req_fifo.sv
// rtl/router_req_fifo.sv - synchronous request FIFO with full/empty/level status
module router_req_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (o_level == '0);
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/router_req_dispatcher.sv
// rtl/router_req_dispatcher.sv - queues router transfer requests, issues them one at a time
// and tracks completion, latency and timeout statistics
module router_req_dispatcher
  import router_4lane_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [ADDR_W-1:0]      i_req_src_addr,
  input  logic [ADDR_W-1:0]      i_req_dst_addr,
  output logic                   o_router_start_req,
  output logic [ADDR_W-1:0]      o_router_scr_addr,
  output logic [ADDR_W-1:0]      o_router_dst_addr,
  input  logic                   i_router_done,
  output logic                   o_cpl_valid,
  output logic [$clog2(DEPTH):0] o_q_level,
  output logic [CNT_W-1:0]       o_xfer_count,
  output logic [CNT_W-1:0]       o_busy_cycles,
  output logic [CNT_W-1:0]       o_last_latency,
  output logic                   o_err_timeout,
  input  logic                   i_stats_clr
);

  disp_state_e         r_state;
  disp_state_e         w_next;
  logic [CNT_W-1:0]    r_lat;
  logic [CNT_W-1:0]    r_xfer;
  logic [CNT_W-1:0]    r_busy;
  logic [CNT_W-1:0]    r_last;
  logic                r_err;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_timeout;
  logic [2*ADDR_W-1:0] w_head;
  logic [CNT_W:0]      w_busy_sum;

  assign w_pop       = (r_state == ST_ISSUE);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign o_req_ready = !w_full || w_pop;
  assign w_push      = i_req_valid && o_req_ready;
  assign w_timeout   = (r_state == ST_WAIT_ACK) && i_router_done &&
                       (r_lat == CNT_W'(ACK_TIMEOUT + 1));

  router_req_fifo #(
    .W     (2*ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata ({i_req_src_addr, i_req_dst_addr}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_q_level)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    o_router_start_req = 1'b0;
    o_cpl_valid        = 1'b0;
    o_router_scr_addr  = '0;
    o_router_dst_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && i_router_done) w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        o_router_start_req = 1'b1;
        o_router_scr_addr  = w_head[2*ADDR_W-1:ADDR_W];
        o_router_dst_addr  = w_head[ADDR_W-1:0];
        w_next             = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!i_router_done) begin
          w_next = ST_WAIT_DONE;
        end else if (w_timeout) begin
          o_cpl_valid = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_router_done) w_next = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        o_cpl_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // r_lat holds the 1-based cycle index of the current transfer; ISSUE is cycle 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_lat <= CNT_W'(2);
    end else if ((r_state == ST_WAIT_ACK || r_state == ST_WAIT_DONE) && r_lat != '1) begin
      r_lat <= r_lat + CNT_W'(1);
    end
  end

  assign w_busy_sum = {1'b0, r_busy} + {1'b0, r_lat};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_xfer <= '0;
      r_busy <= '0;
      r_last <= '0;
      r_err  <= 1'b0;
    end else if (i_stats_clr) begin
      r_xfer <= '0;
      r_busy <= '0;
      r_last <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == ST_COMPLETE) begin
        if (r_xfer != '1) r_xfer <= r_xfer + CNT_W'(1);
        r_busy <= w_busy_sum[CNT_W] ? '1 : w_busy_sum[CNT_W-1:0];
        r_last <= r_lat;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_xfer_count   = r_xfer;
  assign o_busy_cycles  = r_busy;
  assign o_last_latency = r_last;
  assign o_err_timeout  = r_err;

endmodule

// File: tb/tb_router_req_dispatcher.sv
// tb/tb_router_req_dispatcher.sv - randomized scoreboard bench for router_req_dispatcher
module tb_router_req_dispatcher;
  import router_4lane_pkg::*;

  localparam int ADDR_W      = 10;
  localparam int DEPTH       = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int CNT_W       = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_src_addr = '0;
  logic [ADDR_W-1:0] req_dst_addr = '0;
  logic              router_start_req;
  logic [ADDR_W-1:0] router_scr_addr;
  logic [ADDR_W-1:0] router_dst_addr;
  logic              router_done = 1'b0;
  logic              cpl_valid;
  logic [$clog2(DEPTH):0] q_level;
  logic [CNT_W-1:0]  xfer_count;
  logic [CNT_W-1:0]  busy_cycles;
  logic [CNT_W-1:0]  last_latency;
  logic              err_timeout;
  logic              stats_clr = 1'b0;

  router_req_dispatcher #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_src_addr(req_src_addr), .i_req_dst_addr(req_dst_addr),
    .o_router_start_req(router_start_req), .o_router_scr_addr(router_scr_addr),
    .o_router_dst_addr(router_dst_addr), .i_router_done(router_done),
    .o_cpl_valid(cpl_valid), .o_q_level(q_level), .o_xfer_count(xfer_count),
    .o_busy_cycles(busy_cycles), .o_last_latency(last_latency),
    .o_err_timeout(err_timeout), .i_stats_clr(stats_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: request queue, router timing plan and expected statistics.
  router_req_t exp_q[$];
  int    cyc = 0;
  int    lvl = 0;
  bit    outstanding = 0;
  bit    force_low = 1;
  bit    noack = 0;
  bit    exp_to = 0;
  int    lf = -1, lt = -1;
  int    exp_cpl = -1;
  int    exp_lat = 0;
  int    exp_start_cyc = -1;
  longint xfer_m = 0, busy_m = 0, last_m = 0;
  bit    err_m = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    lvl = 0; outstanding = 0; exp_cpl = -1; lf = -1; lt = -1;
    xfer_m = 0; busy_m = 0; last_m = 0; err_m = 0;
  endtask

  task automatic tick(input bit v, input logic [ADDR_W-1:0] s,
                      input logic [ADDR_W-1:0] d, input bit clr);
    router_req_t hd, nr;
    bit st, acc;
    int dly, bl;
    @(posedge clk); #1;
    cyc++;
    router_done  = !(force_low || (cyc >= lf && cyc <= lt));
    req_valid    = v;
    req_src_addr = s;
    req_dst_addr = d;
    stats_clr    = clr;
    #1;
    st  = router_start_req;
    acc = v && (lvl < DEPTH || cyc == exp_start_cyc);
    check("q_level", q_level, lvl);
    if (lvl < DEPTH || cyc == exp_start_cyc) check("req_ready", req_ready, 1);
    else if (force_low) check("req_ready_full", req_ready, 0);
    if (cyc == exp_start_cyc) check("start_time", st, 1);
    check("cpl_valid", cpl_valid, cyc == exp_cpl);
    check("xfer_count", xfer_count, xfer_m);
    check("busy_cycles", busy_cycles, busy_m);
    check("last_latency", last_latency, last_m);
    check("err_timeout", err_timeout, err_m);
    if (st) begin
      check("start_while_busy", outstanding, 0);
      check("start_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        hd = exp_q.pop_front();
        lvl--;
        check("start_src", router_scr_addr, hd.src);
        check("start_dst", router_dst_addr, hd.dst);
      end
      outstanding = 1;
      if (noack) begin
        exp_cpl = cyc + ACK_TIMEOUT;
        exp_to  = 1;
      end else begin
        dly = $urandom_range(0, 3);
        bl  = $urandom_range(1, 6);
        lf  = cyc + 1 + dly;
        lt  = lf + bl - 1;
        exp_cpl = lt + 2;
        exp_lat = exp_cpl - cyc + 1;
        exp_to  = 0;
      end
    end else begin
      check("idle_src_zero", router_scr_addr, 0);
      check("idle_dst_zero", router_dst_addr, 0);
    end
    if (cyc == exp_cpl) begin
      outstanding = 0;
      if (exp_to) err_m = 1;
      else begin
        xfer_m++;
        busy_m += exp_lat;
        last_m = exp_lat;
      end
    end
    if (clr) begin
      xfer_m = 0; busy_m = 0; last_m = 0; err_m = 0;
    end
    if (acc) begin
      nr.src = s;
      nr.dst = d;
      exp_q.push_back(nr);
      lvl++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((lvl != 0 || outstanding) && n < 3000) begin
      tick(0, '0, '0, 0);
      n++;
    end
    check("drain_done", (lvl == 0 && !outstanding), 1);
    tick(0, '0, '0, 0);
    tick(0, '0, '0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, router_start_req, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_qlevel"}, q_level, 0);
    check({tag, "_cpl"}, cpl_valid, 0);
    check({tag, "_src"}, router_scr_addr, 0);
    check({tag, "_dst"}, router_dst_addr, 0);
    check({tag, "_xfer"}, xfer_count, 0);
    check({tag, "_busy"}, busy_cycles, 0);
    check({tag, "_lat"}, last_latency, 0);
    check({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    longint xfer_before;
    int n;

    // Test 1: reset, router comes up, single request
    repeat (4) tick(0, '0, '0, 0);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(0, '0, '0, 0);
    force_low = 0;
    tick(0, '0, '0, 0);
    exp_start_cyc = cyc + 3;
    tick(1, 10'h001, 10'h005, 0);
    drain();
    check("t1_xfer", xfer_count, 1);

    // Test 2: four back-to-back requests after a stats clear
    tick(0, '0, '0, 1);
    tick(1, 10'h000, 10'h009, 0);
    tick(1, 10'h001, 10'h005, 0);
    tick(1, 10'h002, 10'h00F, 0);
    tick(1, 10'h003, 10'h005, 0);
    drain();
    check("t2_xfer", xfer_count, 4);
    check("t2_qlevel", q_level, 0);

    // Randomized traffic with occasional stats clears
    for (int i = 0; i < 250; i++) begin
      tick(($urandom_range(0, 1) == 1) && (lvl < DEPTH), ADDR_W'($urandom),
           ADDR_W'($urandom), $urandom_range(0, 39) == 0);
    end
    drain();

    // Test 3: router held busy, DEPTH+1 pushes
    force_low = 1;
    for (int i = 0; i <= DEPTH; i++) tick(1, ADDR_W'(i + 16), ADDR_W'(i + 100), 0);
    tick(0, '0, '0, 0);
    check("t3_qlevel", q_level, DEPTH);
    check("t3_ready", req_ready, 0);

    // Test 4: full FIFO, router frees, push held through the ISSUE cycle
    force_low = 0;
    exp_start_cyc = cyc + 2;
    tick(1, 10'h3AA, 10'h155, 0);
    tick(1, 10'h3AA, 10'h155, 0);
    tick(0, '0, '0, 0);
    check("t4_qlevel", q_level, DEPTH);
    drain();

    // Test 5: router never acknowledges
    xfer_before = xfer_m;
    noack = 1;
    tick(1, 10'h0AB, 10'h0CD, 0);
    drain();
    noack = 0;
    check("t5_err", err_timeout, 1);
    check("t5_xfer", xfer_count, xfer_before);
    tick(0, '0, '0, 1);
    tick(0, '0, '0, 0);
    check("t5_err_clr", err_timeout, 0);
    tick(1, 10'h011, 10'h022, 0);
    drain();
    check("t5_recover", xfer_count, 1);

    // Test 6: reset during WAIT_DONE with three requests queued
    for (int i = 0; i < 4; i++) tick(1, ADDR_W'(i + 200), ADDR_W'(i + 300), 0);
    n = 0;
    while (!(outstanding && cyc == lf + 1) && n < 200) begin
      tick(0, '0, '0, 0);
      n++;
    end
    check("t6_reach_wait_done", (outstanding && cyc == lf + 1), 1);
    check("t6_queued", q_level, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    model_reset();
    repeat (3) tick(0, '0, '0, 0);
    rst_n = 1'b1;
    repeat (10) tick(0, '0, '0, 0);
    tick(1, 10'h155, 10'h2AA, 0);
    drain();
    check("t6_resume", xfer_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
